// File: rtl/ex_pkg.sv
// Shared types for the MIPS execute stage: ALU opcodes, forwarding selects, multiplier FSM states.
package ex_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_ADDU = 4'd1,
    ALU_SUB  = 4'd2,
    ALU_SUBU = 4'd3,
    ALU_AND  = 4'd4,
    ALU_OR   = 4'd5,
    ALU_XOR  = 4'd6,
    ALU_NOR  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9,
    ALU_SLL  = 4'd10,
    ALU_SRL  = 4'd11,
    ALU_SRA  = 4'd12,
    ALU_LUI  = 4'd13,
    ALU_MUL  = 4'd14
  } alu_op_t;

  localparam logic [1:0] FWD_REG   = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_WB    = 2'b10;

  typedef enum logic {IDLE, RUN} mul_state_t;

endpackage

// File: rtl/ex_stage_param_if.sv
// ID/EX -> EX/MEM bus of the execute stage; slave modport is the EX stage, master is the pipeline around it.
interface ex_stage_param_if #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned RAW  = 5
);
  logic                 id_ex_valid;
  logic [XLEN-1:0]      id_ex_rs_data;
  logic [XLEN-1:0]      id_ex_rt_data;
  logic [RAW-1:0]       id_ex_rt;
  logic [RAW-1:0]       id_ex_rd;
  logic [XLEN-1:0]      id_ex_imm;
  ex_pkg::alu_op_t      alu_op;
  logic                 reg_dst;
  logic                 alu_src;
  logic [1:0]           fwd_a_sel;
  logic [1:0]           fwd_b_sel;
  logic [XLEN-1:0]      wb_value;
  logic                 id_ex_reg_we;
  logic                 id_ex_mem_we;
  logic                 id_ex_mem_re;
  logic                 id_ex_mem_to_reg;
  logic                 mem_stall;
  logic                 ex_flush;
  logic                 ex_busy;
  logic [XLEN-1:0]      ex_mem_alu_out;
  logic [XLEN-1:0]      ex_mem_rt_data;
  logic [RAW-1:0]       ex_mem_dest;
  logic                 ex_mem_valid;
  logic                 ex_mem_reg_we;
  logic                 ex_mem_mem_we;
  logic                 ex_mem_mem_re;
  logic                 ex_mem_mem_to_reg;
  logic                 ex_mem_ovf;

  modport slave (
    input  id_ex_valid, id_ex_rs_data, id_ex_rt_data, id_ex_rt, id_ex_rd, id_ex_imm,
           alu_op, reg_dst, alu_src, fwd_a_sel, fwd_b_sel, wb_value,
           id_ex_reg_we, id_ex_mem_we, id_ex_mem_re, id_ex_mem_to_reg, mem_stall, ex_flush,
    output ex_busy, ex_mem_alu_out, ex_mem_rt_data, ex_mem_dest, ex_mem_valid,
           ex_mem_reg_we, ex_mem_mem_we, ex_mem_mem_re, ex_mem_mem_to_reg, ex_mem_ovf
  );

  modport master (
    output id_ex_valid, id_ex_rs_data, id_ex_rt_data, id_ex_rt, id_ex_rd, id_ex_imm,
           alu_op, reg_dst, alu_src, fwd_a_sel, fwd_b_sel, wb_value,
           id_ex_reg_we, id_ex_mem_we, id_ex_mem_re, id_ex_mem_to_reg, mem_stall, ex_flush,
    input  ex_busy, ex_mem_alu_out, ex_mem_rt_data, ex_mem_dest, ex_mem_valid,
           ex_mem_reg_we, ex_mem_mem_we, ex_mem_mem_re, ex_mem_mem_to_reg, ex_mem_ovf
  );
endinterface

// File: rtl/ex_mul_iter.sv
// Iterative shift-add multiplier, one multiplier bit per edge; low XLEN product bits only.
module ex_mul_iter
  import ex_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            hold,
  input  logic            abort,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] product
);
  localparam int unsigned CW = $clog2(XLEN);

  mul_state_t      state;
  logic [CW-1:0]   cnt;
  logic [XLEN-1:0] acc;
  logic [XLEN-1:0] a_sh;
  logic [XLEN-1:0] b_sh;
  logic [XLEN-1:0] acc_next;

  // product is the accumulator including the bit consumed on the current edge
  assign acc_next = acc + (b_sh[0] ? a_sh : '0);
  assign product  = acc_next;
  assign busy     = (state == RUN);
  assign done     = (state == RUN) && (cnt == CW'(XLEN - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      acc   <= '0;
      a_sh  <= '0;
      b_sh  <= '0;
    end else if (abort) begin
      state <= IDLE;
      cnt   <= '0;
    end else if (!hold) begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sh  <= a;
            b_sh  <= b;
            acc   <= '0;
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          acc  <= acc_next;
          a_sh <= a_sh << 1;
          b_sh <= b_sh >> 1;
          cnt  <= cnt + 1'b1;
          if (cnt == CW'(XLEN - 1)) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: rtl/ex_stage_param.sv
// MIPS execute stage: forwarding, ALU, destination select, EX/MEM register, iterative MUL.
// Optional EX_OVF_TRAP_EN: signed ADD/SUB overflow sets ex_mem_ovf and suppresses write enables.
module ex_stage_param
  import ex_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter int unsigned RAW  = 5
) (
  input logic               clk,
  input logic               rst,
  ex_stage_param_if.slave   bus
);
  localparam int unsigned SW = $clog2(XLEN);

  logic [XLEN-1:0] fwd_a, fwd_b, alu_b, alu_res;
  logic            ovf;
  logic            mul_start, mul_busy, mul_done;
  logic [XLEN-1:0] mul_prod;

  logic            n_valid, n_reg_we, n_mem_we, n_mem_re, n_m2r, n_ovf;
  logic [XLEN-1:0] n_alu, n_rt;
  logic [RAW-1:0]  n_dest;

  always_comb begin
    case (bus.fwd_a_sel)
      FWD_EXMEM: fwd_a = bus.ex_mem_alu_out;
      FWD_WB:    fwd_a = bus.wb_value;
      default:   fwd_a = bus.id_ex_rs_data;
    endcase
    case (bus.fwd_b_sel)
      FWD_EXMEM: fwd_b = bus.ex_mem_alu_out;
      FWD_WB:    fwd_b = bus.wb_value;
      default:   fwd_b = bus.id_ex_rt_data;
    endcase
  end

  assign alu_b = bus.alu_src ? bus.id_ex_imm : fwd_b;

  always_comb begin
    alu_res = '0;
    ovf     = 1'b0;
    case (bus.alu_op)
      ALU_ADD, ALU_ADDU: alu_res = fwd_a + alu_b;
      ALU_SUB, ALU_SUBU: alu_res = fwd_a - alu_b;
      ALU_AND:  alu_res = fwd_a & alu_b;
      ALU_OR:   alu_res = fwd_a | alu_b;
      ALU_XOR:  alu_res = fwd_a ^ alu_b;
      ALU_NOR:  alu_res = ~(fwd_a | alu_b);
      ALU_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(fwd_a) < $signed(alu_b))};
      ALU_SLTU: alu_res = {{(XLEN-1){1'b0}}, (fwd_a < alu_b)};
      ALU_SLL:  alu_res = fwd_a << alu_b[SW-1:0];
      ALU_SRL:  alu_res = fwd_a >> alu_b[SW-1:0];
      ALU_SRA:  alu_res = $unsigned($signed(fwd_a) >>> alu_b[SW-1:0]);
      ALU_LUI:  alu_res = alu_b << (XLEN / 2);
      default:  alu_res = '0;
    endcase
`ifdef EX_OVF_TRAP_EN
    if (bus.alu_op == ALU_ADD)
      ovf = (fwd_a[XLEN-1] == alu_b[XLEN-1]) && (alu_res[XLEN-1] != fwd_a[XLEN-1]);
    else if (bus.alu_op == ALU_SUB)
      ovf = (fwd_a[XLEN-1] != alu_b[XLEN-1]) && (alu_res[XLEN-1] != fwd_a[XLEN-1]);
`endif
  end

  assign mul_start   = bus.id_ex_valid && (bus.alu_op == ALU_MUL) && !mul_busy;
  assign bus.ex_busy = mul_start || mul_busy || bus.mem_stall;

  ex_mul_iter #(.XLEN(XLEN)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start),
    .hold    (bus.mem_stall),
    .abort   (bus.ex_flush),
    .a       (fwd_a),
    .b       (fwd_b),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_prod)
  );

  // MUL writeback takes control fields from ID/EX, which upstream holds while ex_busy is high
  always_comb begin
    n_valid  = 1'b0;
    n_alu    = '0;
    n_rt     = '0;
    n_dest   = '0;
    n_reg_we = 1'b0;
    n_mem_we = 1'b0;
    n_mem_re = 1'b0;
    n_m2r    = 1'b0;
    n_ovf    = 1'b0;
    if ((mul_busy && mul_done) || (!mul_busy && !mul_start && bus.id_ex_valid)) begin
      n_valid  = 1'b1;
      n_alu    = mul_busy ? mul_prod : alu_res;
      n_rt     = fwd_b;
      n_dest   = bus.reg_dst ? bus.id_ex_rd : bus.id_ex_rt;
      n_ovf    = mul_busy ? 1'b0 : ovf;
      n_reg_we = bus.id_ex_reg_we && !n_ovf;
      n_mem_we = bus.id_ex_mem_we && !n_ovf;
      n_mem_re = bus.id_ex_mem_re;
      n_m2r    = bus.id_ex_mem_to_reg;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst || bus.ex_flush) begin
      bus.ex_mem_valid      <= 1'b0;
      bus.ex_mem_alu_out    <= '0;
      bus.ex_mem_rt_data    <= '0;
      bus.ex_mem_dest       <= '0;
      bus.ex_mem_reg_we     <= 1'b0;
      bus.ex_mem_mem_we     <= 1'b0;
      bus.ex_mem_mem_re     <= 1'b0;
      bus.ex_mem_mem_to_reg <= 1'b0;
      bus.ex_mem_ovf        <= 1'b0;
    end else if (!bus.mem_stall) begin
      bus.ex_mem_valid      <= n_valid;
      bus.ex_mem_alu_out    <= n_alu;
      bus.ex_mem_rt_data    <= n_rt;
      bus.ex_mem_dest       <= n_dest;
      bus.ex_mem_reg_we     <= n_reg_we;
      bus.ex_mem_mem_we     <= n_mem_we;
      bus.ex_mem_mem_re     <= n_mem_re;
      bus.ex_mem_mem_to_reg <= n_m2r;
      bus.ex_mem_ovf        <= n_ovf;
    end
  end
endmodule

// File: tb/tb_ex_stage_param.sv
// Directed bench for ex_stage_param (XLEN=32); honours EX_OVF_TRAP_EN for the overflow case.
module tb_ex_stage_param;
  import ex_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  ex_stage_param_if #(.XLEN(32), .RAW(5)) bus ();

  ex_stage_param #(.XLEN(32), .RAW(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  alu_op_t     t_op [12] = '{ALU_AND, ALU_OR, ALU_XOR, ALU_NOR, ALU_SLT, ALU_SLTU,
                             ALU_SLL, ALU_SRL, ALU_SRA, ALU_LUI, ALU_SUBU, ALU_ADDU};
  logic [31:0] t_a  [12] = '{32'hF0F0_1234, 32'hF0F0_1234, 32'hF0F0_1234, 32'h0000_FFFF,
                             32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32'h8000_0000,
                             32'h8000_0000, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF};
  logic [31:0] t_b  [12] = '{32'h0FF0_FF00, 32'h0FF0_FF00, 32'h0FF0_FF00, 32'h00FF_0000,
                             32'h0000_0001, 32'h0000_0001, 32'h0000_0024, 32'h0000_001F,
                             32'h0000_0004, 32'h0000_1234, 32'h0000_0001, 32'h0000_0002};
  logic [31:0] t_e  [12] = '{32'h00F0_1200, 32'hFFF0_FF34, 32'hFF00_ED34, 32'hFF00_0000,
                             32'h0000_0001, 32'h0000_0000, 32'h0000_0010, 32'h0000_0001,
                             32'hF800_0000, 32'h1234_0000, 32'hFFFF_FFFF, 32'h0000_0001};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic op(input alu_op_t o, input logic [31:0] a, input logic [31:0] b);
    bus.id_ex_valid   = 1'b1;
    bus.alu_op        = o;
    bus.id_ex_rs_data = a;
    bus.id_ex_rt_data = b;
    bus.alu_src       = 1'b0;
    bus.fwd_a_sel     = 2'b00;
    bus.fwd_b_sel     = 2'b00;
  endtask

  initial begin
    bus.id_ex_valid = 1'b0; bus.id_ex_rs_data = '0; bus.id_ex_rt_data = '0;
    bus.id_ex_rt = '0; bus.id_ex_rd = '0; bus.id_ex_imm = '0; bus.alu_op = ALU_ADD;
    bus.reg_dst = 1'b0; bus.alu_src = 1'b0; bus.fwd_a_sel = '0; bus.fwd_b_sel = '0;
    bus.wb_value = '0; bus.id_ex_reg_we = 1'b0; bus.id_ex_mem_we = 1'b0;
    bus.id_ex_mem_re = 1'b0; bus.id_ex_mem_to_reg = 1'b0; bus.mem_stall = 1'b0;
    bus.ex_flush = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 32'(bus.ex_mem_valid), 32'd0);
    check("rst_alu", bus.ex_mem_alu_out, 32'd0);
    check("rst_regwe", 32'(bus.ex_mem_reg_we), 32'd0);
    check("rst_busy", 32'(bus.ex_busy), 32'd0);
    rst = 1'b0;

    // ADD 5+7 into Rd
    op(ALU_ADD, 32'd5, 32'd7);
    bus.id_ex_rt = 5'd3; bus.id_ex_rd = 5'd4; bus.reg_dst = 1'b1; bus.id_ex_reg_we = 1'b1;
    step();
    check("add_res", bus.ex_mem_alu_out, 32'd12);
    check("add_valid", 32'(bus.ex_mem_valid), 32'd1);
    check("add_dest", 32'(bus.ex_mem_dest), 32'd4);
    check("add_regwe", 32'(bus.ex_mem_reg_we), 32'd1);

    // produce 0x10, then SUB forwarded-from-EX/MEM minus imm 4, dest=Rt
    op(ALU_ADD, 32'h10, 32'h0);
    step();
    check("fwd_src", bus.ex_mem_alu_out, 32'h10);
    op(ALU_SUB, 32'h99, 32'h0);
    bus.fwd_a_sel = 2'b01; bus.alu_src = 1'b1; bus.id_ex_imm = 32'd4;
    bus.reg_dst = 1'b0; bus.id_ex_rt = 5'd7;
    step();
    check("sub_fwd", bus.ex_mem_alu_out, 32'h0C);
    check("sub_dest", 32'(bus.ex_mem_dest), 32'd7);

    // SW: address = rs + imm, store data forwarded from WB
    op(ALU_ADD, 32'h100, 32'h55);
    bus.alu_src = 1'b1; bus.id_ex_imm = 32'd8; bus.fwd_b_sel = 2'b10; bus.wb_value = 32'd9;
    bus.id_ex_reg_we = 1'b0; bus.id_ex_mem_we = 1'b1;
    step();
    check("sw_addr", bus.ex_mem_alu_out, 32'h108);
    check("sw_data", bus.ex_mem_rt_data, 32'd9);
    check("sw_memwe", 32'(bus.ex_mem_mem_we), 32'd1);
    check("sw_regwe", 32'(bus.ex_mem_reg_we), 32'd0);
    bus.id_ex_mem_we = 1'b0; bus.id_ex_reg_we = 1'b1;

    for (int i = 0; i < 12; i++) begin
      op(t_op[i], t_a[i], t_b[i]);
      step();
      check($sformatf("alu_%s", t_op[i].name()), bus.ex_mem_alu_out, t_e[i]);
    end

    // bubble clears valid and enables
    bus.id_ex_valid = 1'b0;
    step();
    check("bub_valid", 32'(bus.ex_mem_valid), 32'd0);
    check("bub_regwe", 32'(bus.ex_mem_reg_we), 32'd0);

    // MUL 0xFFFF * 3, operands scrambled after accept
    op(ALU_MUL, 32'h0000_FFFF, 32'h3);
    bus.reg_dst = 1'b1; bus.id_ex_rd = 5'd9;
    #1;
    check("mul_busy_comb", 32'(bus.ex_busy), 32'd1);
    for (int e = 1; e <= 32; e++) begin
      step();
      check($sformatf("mul_bub_e%0d", e), 32'(bus.ex_mem_valid), 32'd0);
      check($sformatf("mul_busy_e%0d", e), 32'(bus.ex_busy), 32'd1);
      if (e == 1) begin
        bus.id_ex_rs_data = 32'h1234; bus.id_ex_rt_data = 32'h5678; bus.fwd_a_sel = 2'b10;
      end
    end
    step();
    check("mul_res", bus.ex_mem_alu_out, 32'h0002_FFFD);
    check("mul_valid", 32'(bus.ex_mem_valid), 32'd1);
    check("mul_dest", 32'(bus.ex_mem_dest), 32'd9);
    bus.id_ex_valid = 1'b0;
    #1;
    check("mul_busy_after", 32'(bus.ex_busy), 32'd0);

    // flush a MUL at cnt=10
    op(ALU_MUL, 32'd5, 32'd6);
    repeat (11) step();
    check("fl_pre_busy", 32'(bus.ex_busy), 32'd1);
    check("fl_pre_valid", 32'(bus.ex_mem_valid), 32'd0);
    bus.ex_flush = 1'b1; bus.id_ex_valid = 1'b0;
    step();
    bus.ex_flush = 1'b0;
    #1;
    check("fl_valid", 32'(bus.ex_mem_valid), 32'd0);
    check("fl_busy", 32'(bus.ex_busy), 32'd0);
    op(ALU_ADD, 32'd2, 32'd3);
    step();
    check("fl_add", bus.ex_mem_alu_out, 32'd5);
    check("fl_add_valid", 32'(bus.ex_mem_valid), 32'd1);
    bus.id_ex_valid = 1'b0;
    step();
    check("fl_no_ghost", 32'(bus.ex_mem_valid), 32'd0);

    // mem_stall for 3 edges
    op(ALU_ADD, 32'd20, 32'd22);
    step();
    check("st_pre", bus.ex_mem_alu_out, 32'd42);
    op(ALU_ADD, 32'd100, 32'd1);
    bus.mem_stall = 1'b1;
    #1;
    check("st_busy", 32'(bus.ex_busy), 32'd1);
    for (int s = 0; s < 3; s++) begin
      step();
      check($sformatf("st_hold%0d", s), bus.ex_mem_alu_out, 32'd42);
    end
    bus.mem_stall = 1'b0;
    step();
    check("st_after", bus.ex_mem_alu_out, 32'd101);

    // signed overflow on ADD
    op(ALU_ADD, 32'h7FFF_FFFF, 32'h1);
    bus.id_ex_reg_we = 1'b1;
    step();
    check("ovf_res", bus.ex_mem_alu_out, 32'h8000_0000);
`ifdef EX_OVF_TRAP_EN
    check("ovf_flag", 32'(bus.ex_mem_ovf), 32'd1);
    check("ovf_regwe", 32'(bus.ex_mem_reg_we), 32'd0);
`else
    check("ovf_flag", 32'(bus.ex_mem_ovf), 32'd0);
    check("ovf_regwe", 32'(bus.ex_mem_reg_we), 32'd1);
`endif
    op(ALU_ADDU, 32'h7FFF_FFFF, 32'h1);
    step();
    check("addu_noovf", 32'(bus.ex_mem_ovf), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
